id_imm_sequencer: RTL and testbench

Decode-stage controller for the 16-bit pipelined CPU.
- Holds the IF/ID instruction register and decodes the opcode into a 4-bit immediate-select code.
- Drives the immediate extension unit, then registers the 16-bit immediate and control bits into the ID/EX boundary.
- Sequences stalls (load-use bubble) and flushes (taken branch) across both registers.

---
 rtl/id_imm_sequencer_pkg.sv | 60 ++++++
 rtl/id_imm_sequencer_if.sv | 28 ++
 rtl/id_imm_sequencer_imm_extend_unit.sv | 24 ++
 rtl/id_imm_sequencer.sv | 119 +++++++++++
 tb/tb_id_imm_sequencer.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/id_imm_sequencer_pkg.sv
// Decode-stage shared definitions: opcodes, immediate-select codes, FSM states,
// the ID/EX slot payload and the opcode-to-select decoder.
package id_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned SEL_W   = 4;
  localparam int unsigned REG_W   = 3;

  localparam logic [INSTR_W-1:0] NOP_WORD = 16'h0800;

  localparam logic [4:0] OP_B      = 5'b00010;
  localparam logic [4:0] OP_BEQZ   = 5'b00100;
  localparam logic [4:0] OP_BNEZ   = 5'b00101;
  localparam logic [4:0] OP_SHIFT  = 5'b00110;
  localparam logic [4:0] OP_ADDIU3 = 5'b01000;
  localparam logic [4:0] OP_ADDIU  = 5'b01001;
  localparam logic [4:0] OP_SLTI   = 5'b01010;
  localparam logic [4:0] OP_ADDSP  = 5'b01100;
  localparam logic [4:0] OP_LI     = 5'b01101;
  localparam logic [4:0] OP_CMPI   = 5'b01110;
  localparam logic [4:0] OP_LW_SP  = 5'b10010;
  localparam logic [4:0] OP_LW     = 5'b10011;
  localparam logic [4:0] OP_SW_SP  = 5'b11010;
  localparam logic [4:0] OP_SW     = 5'b11011;

  localparam logic [SEL_W-1:0] IMM_SEL_ZE8   = 4'b0000;
  localparam logic [SEL_W-1:0] IMM_SEL_SHAMT = 4'b0101;
  localparam logic [SEL_W-1:0] IMM_SEL_SE8   = 4'b1000;
  localparam logic [SEL_W-1:0] IMM_SEL_SE4   = 4'b1001;
  localparam logic [SEL_W-1:0] IMM_SEL_SE5   = 4'b1010;
  localparam logic [SEL_W-1:0] IMM_SEL_SE11  = 4'b1011;

  typedef enum logic {ST_RUN, ST_BUBBLE} id_state_e;

  // Contents of the ID/EX boundary register.
  typedef struct packed {
    logic               valid;
    logic [INSTR_W-1:0] imm;
    logic [SEL_W-1:0]   imm_sel;
    logic               is_load;
    logic [REG_W-1:0]   load_dst;
  } ex_slot_t;

  // Map a major opcode to its immediate-select code.
  function automatic logic [SEL_W-1:0] imm_sel_of(input logic [4:0] op);
    logic [SEL_W-1:0] sel;
    sel = IMM_SEL_ZE8;
    case (op)
      OP_ADDIU, OP_SLTI, OP_CMPI, OP_ADDSP,
      OP_BEQZ, OP_BNEZ, OP_LW_SP, OP_SW_SP: sel = IMM_SEL_SE8;
      OP_ADDIU3:                            sel = IMM_SEL_SE4;
      OP_LW, OP_SW:                         sel = IMM_SEL_SE5;
      OP_B:                                 sel = IMM_SEL_SE11;
      OP_SHIFT:                             sel = IMM_SEL_SHAMT;
      default:                              sel = IMM_SEL_ZE8;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/id_imm_sequencer_if.sv
// Fetch/decode/execute boundary signals of the decode-stage controller.
interface id_imm_sequencer_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic [15:0]      if_instr;
  logic             if_valid;
  logic             ex_flush;
  logic             pc_stall;
  logic [15:0]      id_instr;
  logic             ex_valid;
  logic [15:0]      ex_imm;
  logic [3:0]       ex_imm_sel;
  logic             ex_is_load;
  logic [2:0]       ex_load_dst;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output if_instr, if_valid, ex_flush,
    input  pc_stall, id_instr, ex_valid, ex_imm, ex_imm_sel,
           ex_is_load, ex_load_dst, stall_cnt
  );

  modport slave (
    input  if_instr, if_valid, ex_flush,
    output pc_stall, id_instr, ex_valid, ex_imm, ex_imm_sel,
           ex_is_load, ex_load_dst, stall_cnt
  );
endinterface

// File: rtl/id_imm_sequencer_imm_extend_unit.sv
// Combinational immediate extension: select code + instruction low field -> 16-bit immediate.
module imm_extend_unit
  import id_pkg::*;
(
  input  logic [SEL_W-1:0]   imm_sel,
  input  logic [10:0]        field,
  output logic [INSTR_W-1:0] imm_c
);

  // Sign/zero extend the field chosen by the select code.
  always_comb begin
    imm_c = '0;
    case (imm_sel)
      IMM_SEL_SE8:   imm_c = {{8{field[7]}}, field[7:0]};
      IMM_SEL_SE4:   imm_c = {{12{field[3]}}, field[3:0]};
      IMM_SEL_SE5:   imm_c = {{11{field[4]}}, field[4:0]};
      IMM_SEL_SE11:  imm_c = {{5{field[10]}}, field[10:0]};
      IMM_SEL_ZE8:   imm_c = {8'h00, field[7:0]};
      IMM_SEL_SHAMT: imm_c = (field[4:2] == 3'b000) ? 16'h0008 : {13'h0000, field[4:2]};
      default:       imm_c = '0;
    endcase
  end

endmodule

// File: rtl/id_imm_sequencer.sv
// Decode-stage controller: IF/ID register, immediate decode/extension, ID/EX
// register and load-use stall / branch flush sequencing.
// Optional feature macro: ID_STALL_COUNTER_EN (saturating stall-cycle counter).
module id_imm_sequencer
  import id_pkg::*;
#(
  parameter logic [15:0] NOP_INSTR = NOP_WORD,
  parameter int unsigned CNT_W     = 16
) (
  input logic             clk,
  input logic             rst,
  id_imm_sequencer_if.slave bus
);

  id_state_e          state;
  logic [INSTR_W-1:0] id_instr;
  logic               id_valid;
  ex_slot_t           ex_q;
  ex_slot_t           id_slot_c;
  logic [SEL_W-1:0]   id_sel_c;
  logic [INSTR_W-1:0] id_imm_c;
  logic               id_is_load_c;
  logic [REG_W-1:0]   id_load_dst_c;
  logic               hazard_c;
  logic               pc_stall_c;
  logic [CNT_W-1:0]   stall_cnt;

  assign id_sel_c = imm_sel_of(id_instr[15:11]);

  imm_extend_unit u_imm_extend (
    .imm_sel (id_sel_c),
    .field   (id_instr[10:0]),
    .imm_c   (id_imm_c)
  );

  // Load detection and destination register of the instruction in decode.
  always_comb begin
    id_is_load_c  = 1'b0;
    id_load_dst_c = '0;
    if (id_instr[15:11] == OP_LW) begin
      id_is_load_c  = 1'b1;
      id_load_dst_c = id_instr[7:5];
    end else if (id_instr[15:11] == OP_LW_SP) begin
      id_is_load_c  = 1'b1;
      id_load_dst_c = id_instr[10:8];
    end
  end

  assign id_slot_c = '{valid:    id_valid,
                       imm:      id_imm_c,
                       imm_sel:  id_sel_c,
                       is_load:  id_is_load_c,
                       load_dst: id_load_dst_c};

  // Conservative load-use check: either register field of decode may be a source.
  assign hazard_c = ex_q.valid & ex_q.is_load & id_valid &
                    ((ex_q.load_dst == id_instr[10:8]) | (ex_q.load_dst == id_instr[7:5]));

  // Fetch hold is only raised from RUN and is overridden by flush and reset.
  assign pc_stall_c = (state == ST_RUN) & hazard_c & ~bus.ex_flush & ~rst;

  // Pipeline sequencer: reset > flush > stall/advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RUN;
      id_instr <= NOP_INSTR;
      id_valid <= 1'b0;
      ex_q     <= '0;
    end else if (bus.ex_flush) begin
      state    <= ST_RUN;
      id_instr <= NOP_INSTR;
      id_valid <= 1'b0;
      ex_q     <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (hazard_c) begin
            ex_q  <= '0;
            state <= ST_BUBBLE;
          end else begin
            id_instr <= bus.if_instr;
            id_valid <= bus.if_valid;
            ex_q     <= id_slot_c;
          end
        end
        ST_BUBBLE: begin
          id_instr <= bus.if_instr;
          id_valid <= bus.if_valid;
          ex_q     <= id_slot_c;
          state    <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

`ifdef ID_STALL_COUNTER_EN
  // Saturating count of stalled cycles, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (pc_stall_c && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
`else
  assign stall_cnt = '0;
`endif

  assign bus.pc_stall    = pc_stall_c;
  assign bus.id_instr    = id_instr;
  assign bus.ex_valid    = ex_q.valid;
  assign bus.ex_imm      = ex_q.imm;
  assign bus.ex_imm_sel  = ex_q.imm_sel;
  assign bus.ex_is_load  = ex_q.is_load;
  assign bus.ex_load_dst = ex_q.load_dst;
  assign bus.stall_cnt   = stall_cnt;

endmodule

// File: tb/tb_id_imm_sequencer.sv
// Scoreboard bench for id_imm_sequencer: directed plan items followed by
// random instruction streams with random flushes and resets.
module tb_id_imm_sequencer;

  typedef struct {
    logic [15:0] instr;
    bit          valid;
    bit          flush;
    bit          rst;
  } item_t;

  typedef struct {
    logic [15:0] word;
    logic [15:0] imm;
    logic [3:0]  sel;
    logic        is_load;
    logic [2:0]  dst;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  id_imm_sequencer_if #(.CNT_W(16)) bus ();

  id_imm_sequencer #(.NOP_INSTR(16'h0800), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  bit    done   = 0;
  exp_t  exp_q[$];
  item_t stim[$];

  // Decode-pipeline model at instruction granularity
  logic [15:0] m_id_word = 16'h0800;
  bit          m_id_v    = 0;
  logic [15:0] m_ex_word = 16'h0000;
  bit          m_ex_v    = 0;
  int          m_stalls  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] ref_sel(input logic [15:0] w);
    int op;
    op = int'(w[15:11]);
    case (op)
      9, 10, 14, 12, 4, 5, 18, 26: return 4'd8;
      8:                           return 4'd9;
      19, 27:                      return 4'd10;
      2:                           return 4'd11;
      6:                           return 4'd5;
      default:                     return 4'd0;
    endcase
  endfunction

  function automatic logic [15:0] ref_imm(input logic [15:0] w);
    int v;
    case (ref_sel(w))
      4'd8:  begin v = int'(w[7:0]);  if (v > 127)  v -= 256;  end
      4'd9:  begin v = int'(w[3:0]);  if (v > 7)    v -= 16;   end
      4'd10: begin v = int'(w[4:0]);  if (v > 15)   v -= 32;   end
      4'd11: begin v = int'(w[10:0]); if (v > 1023) v -= 2048; end
      4'd5:  begin v = int'(w[4:2]);  if (v == 0)   v = 8;     end
      default: v = int'(w[7:0]);
    endcase
    return 16'(v);
  endfunction

  function automatic bit ref_is_load(input logic [15:0] w);
    return (w[15:11] == 5'd19) || (w[15:11] == 5'd18);
  endfunction

  function automatic logic [2:0] ref_dst(input logic [15:0] w);
    if (w[15:11] == 5'd19) return w[7:5];
    if (w[15:11] == 5'd18) return w[10:8];
    return 3'd0;
  endfunction

  function automatic exp_t mk_exp(input logic [15:0] w);
    exp_t e;
    e.word    = w;
    e.imm     = ref_imm(w);
    e.sel     = ref_sel(w);
    e.is_load = ref_is_load(w);
    e.dst     = ref_dst(w);
    return e;
  endfunction

  function automatic item_t mk(input logic [15:0] w, input bit v, input bit f, input bit r);
    item_t it;
    it.instr = w; it.valid = v; it.flush = f; it.rst = r;
    return it;
  endfunction

  function automatic logic [15:0] rand_instr();
    logic [4:0]  ops [16];
    logic [15:0] w;
    ops = '{5'b01001, 5'b01010, 5'b01110, 5'b01100, 5'b00100, 5'b00101, 5'b10010, 5'b11010,
            5'b01000, 5'b10011, 5'b11011, 5'b00010, 5'b01101, 5'b00110, 5'b11100, 5'b10011};
    w        = 16'($urandom);
    w[15:11] = ops[$urandom_range(0, 15)];
    w[10:8]  = 3'($urandom_range(0, 3));
    w[7:5]   = 3'($urandom_range(0, 3));
    return w;
  endfunction

  // Monitor: every valid EX slot must match the oldest expected instruction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!done && bus.ex_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("ex_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("ex_imm", bus.ex_imm, e.imm);
          chk("ex_imm_sel", bus.ex_imm_sel, e.sel);
          chk("ex_is_load", bus.ex_is_load, e.is_load);
          if (e.is_load) chk("ex_load_dst", bus.ex_load_dst, e.dst);
        end
      end
    end
  end

  // Driver and cycle-level model.
  initial begin
    item_t it;
    bit    pred_stall;
    bit    ex_ld;
    int    cycles;
    bus.if_instr = 16'h0000;
    bus.if_valid = 1'b0;
    bus.ex_flush = 1'b0;
    rst          = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_id_instr", bus.id_instr, 16'h0800);
    chk("rst_ex_valid", bus.ex_valid, 1'b0);
    chk("rst_ex_imm", bus.ex_imm, 16'h0000);
    chk("rst_ex_imm_sel", bus.ex_imm_sel, 4'h0);
    chk("rst_ex_is_load", bus.ex_is_load, 1'b0);
    chk("rst_ex_load_dst", bus.ex_load_dst, 3'd0);
    chk("rst_pc_stall", bus.pc_stall, 1'b0);
    chk("rst_stall_cnt", bus.stall_cnt, 16'd0);

    // Directed plan items
    stim.push_back(mk(16'h4BFF, 1, 0, 0));
    stim.push_back(mk(16'h6880, 1, 0, 0));
    stim.push_back(mk(16'h17FF, 1, 0, 0));
    stim.push_back(mk(16'h3000, 1, 0, 0));
    stim.push_back(mk(16'h300C, 1, 0, 0));
    stim.push_back(mk(16'h9860, 1, 0, 0));
    stim.push_back(mk(16'hE300, 1, 0, 0));
    stim.push_back(mk(16'h4BFF, 0, 0, 0));
    repeat (3) stim.push_back(mk(16'h0000, 0, 0, 0));
    stim.push_back(mk(16'h9860, 1, 0, 0));
    stim.push_back(mk(16'hE300, 1, 0, 0));
    stim.push_back(mk(16'h4B01, 1, 1, 0));
    stim.push_back(mk(16'h9860, 1, 0, 0));
    stim.push_back(mk(16'h9860, 1, 0, 0));
    stim.push_back(mk(16'hE300, 1, 0, 0));
    stim.push_back(mk(16'h6801, 1, 0, 1));
    repeat (2) stim.push_back(mk(16'h0000, 0, 0, 0));
    // Random stream
    for (int i = 0; i < 600; i++) begin
      stim.push_back(mk(rand_instr(), ($urandom_range(0, 99) < 85),
                        ($urandom_range(0, 99) < 4), ($urandom_range(0, 199) == 0)));
    end
    repeat (4) stim.push_back(mk(16'h0000, 0, 0, 0));

    rst = 1'b0;
    cycles = 0;
    while (stim.size() > 0) begin
      it = stim[0];
      rst          = it.rst;
      bus.if_instr = it.instr;
      bus.if_valid = it.valid;
      bus.ex_flush = it.flush;
      @(negedge clk);
      #1;
      ex_ld      = m_ex_v && ref_is_load(m_ex_word);
      pred_stall = !it.rst && !it.flush && ex_ld && m_id_v &&
                   ((ref_dst(m_ex_word) == m_id_word[10:8]) || (ref_dst(m_ex_word) == m_id_word[7:5]));
      chk("pc_stall", bus.pc_stall, pred_stall);
      chk("id_instr", bus.id_instr, m_id_word);
      chk("ex_valid", bus.ex_valid, m_ex_v);
`ifdef ID_STALL_COUNTER_EN
      chk("stall_cnt", bus.stall_cnt, 32'(m_stalls));
`else
      chk("stall_cnt", bus.stall_cnt, 32'd0);
`endif
      if (it.rst) begin
        m_id_word = 16'h0800; m_id_v = 0; m_ex_v = 0; m_stalls = 0;
        exp_q.delete();
      end else if (it.flush) begin
        m_id_word = 16'h0800; m_id_v = 0; m_ex_v = 0;
        exp_q.delete();
      end else if (pred_stall) begin
        m_ex_v = 0;
        m_stalls++;
      end else begin
        m_ex_v    = m_id_v;
        m_ex_word = m_id_word;
        m_id_word = it.instr;
        m_id_v    = it.valid;
        if (it.valid) exp_q.push_back(mk_exp(it.instr));
      end
      if (!pred_stall) void'(stim.pop_front());
      @(posedge clk);
      #1;
      cycles++;
      if (cycles > 20000) begin
        chk("cycle_budget", 32'(cycles), 32'd20000);
        break;
      end
    end

    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("final_rst_stall_cnt", bus.stall_cnt, 16'd0);
    chk("final_rst_id_instr", bus.id_instr, 16'h0800);
    done = 1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
